// File: rtl/dog_extrema_detect.sv
// rtl/dog_extrema_detect.sv - 3x3 single-scale local-maximum detector on the DoG pixel stream.
// Optional per-frame keypoint counter output enabled by defining DOG_KEY_COUNT_EN.
module dog_extrema_detect #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 8,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          irst,
    input  logic [8:0]    idata,
    output logic          okey,
    output logic [CW-1:0] ox,
    output logic [CW-1:0] oy,
    output logic [7:0]    ocenter,
    output logic          oframe_done
`ifdef DOG_KEY_COUNT_EN
    ,
    output logic [15:0]   okey_count
`endif
);

    typedef enum logic {FILL, SCAN} state_t;

    state_t        state;
    logic [CW-1:0] x;
    logic [CW-1:0] y;

    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];

    // Index 0 is the newest column, index 2 the oldest; the center is row mid, index 1.
    logic [2:0][7:0] w_top;
    logic [2:0][7:0] w_mid;
    logic [2:0][7:0] w_bot;

    logic          valid;
    logic [7:0]    pix;
    logic [7:0]    top_rd;
    logic [7:0]    mid_rd;
    logic          last_pix;

    logic          ev1;
    logic          last1;
    logic [CW-1:0] cx1;
    logic [CW-1:0] cy1;

    logic          key2;
    logic          last2;
    logic [CW-1:0] cx2;
    logic [CW-1:0] cy2;
    logic [7:0]    c2;

    logic          is_max;

    assign valid    = idata[8];
    assign pix      = idata[7:0];
    assign top_rd   = lb2[x];
    assign mid_rd   = lb1[x];
    assign last_pix = (x == CW'(IMG_W - 1)) && (y == CW'(IMG_H - 1));

    // Line buffers carry no reset: every row is rewritten before the window can read it.
    always_ff @(posedge clk) begin
        if (valid) begin
            lb2[x] <= mid_rd;
            lb1[x] <= pix;
        end
    end

    always_comb begin
        is_max = (w_mid[1] > 8'(THRESH));
        for (int i = 0; i < 3; i++) begin
            if (w_top[i] >= w_mid[1]) is_max = 1'b0;
            if (w_bot[i] >= w_mid[1]) is_max = 1'b0;
        end
        if (w_mid[0] >= w_mid[1]) is_max = 1'b0;
        if (w_mid[2] >= w_mid[1]) is_max = 1'b0;
    end

    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            state       <= FILL;
            x           <= '0;
            y           <= '0;
            w_top       <= '0;
            w_mid       <= '0;
            w_bot       <= '0;
            ev1         <= 1'b0;
            last1       <= 1'b0;
            cx1         <= '0;
            cy1         <= '0;
            key2        <= 1'b0;
            last2       <= 1'b0;
            cx2         <= '0;
            cy2         <= '0;
            c2          <= '0;
            okey        <= 1'b0;
            ox          <= '0;
            oy          <= '0;
            ocenter     <= '0;
            oframe_done <= 1'b0;
        end else begin
            ev1   <= 1'b0;
            last1 <= 1'b0;
            if (valid) begin
                w_top <= {w_top[1:0], top_rd};
                w_mid <= {w_mid[1:0], mid_rd};
                w_bot <= {w_bot[1:0], pix};
                // x < 2 keeps the window from straddling a line wrap.
                ev1   <= (state == SCAN) && (x >= CW'(2));
                last1 <= last_pix;
                cx1   <= x - CW'(1);
                cy1   <= y - CW'(1);

                if (x == CW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= (y == CW'(IMG_H - 1)) ? '0 : y + CW'(1);
                end else begin
                    x <= x + CW'(1);
                end

                case (state)
                    FILL: if (y == CW'(2)) state <= SCAN;
                    SCAN: if (last_pix) state <= FILL;
                    default: state <= FILL;
                endcase
            end

            key2  <= ev1 && is_max;
            last2 <= last1;
            cx2   <= cx1;
            cy2   <= cy1;
            c2    <= w_mid[1];

            okey        <= key2;
            oframe_done <= last2;
            if (key2) begin
                ox      <= cx2;
                oy      <= cy2;
                ocenter <= c2;
            end
        end
    end

`ifdef DOG_KEY_COUNT_EN
    logic [15:0] kcnt;
    logic [15:0] kcnt_next;

    assign kcnt_next = (key2 && (kcnt != 16'hFFFF)) ? kcnt + 16'd1 : kcnt;

    // Latch aligns with oframe_done so a keypoint on the final pixel is included.
    always_ff @(posedge clk or posedge irst) begin
        if (irst) begin
            kcnt       <= '0;
            okey_count <= '0;
        end else if (last2) begin
            okey_count <= kcnt_next;
            kcnt       <= '0;
        end else begin
            kcnt <= kcnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_dog_extrema_detect.sv
// tb/tb_dog_extrema_detect.sv - scoreboard bench for dog_extrema_detect on an 8x8 frame.
module tb_dog_extrema_detect;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int TH = 8;
    localparam int CW = 10;

    typedef struct {
        int due;
        int x;
        int y;
        int c;
    } key_t;

    logic          clk = 1'b0;
    logic          irst;
    logic [8:0]    idata;
    logic          okey;
    logic [CW-1:0] ox;
    logic [CW-1:0] oy;
    logic [7:0]    ocenter;
    logic          oframe_done;
`ifdef DOG_KEY_COUNT_EN
    logic [15:0]   okey_count;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   keys_seen;
    int   frames_seen;
    int   last_x, last_y, last_c;
    key_t key_q[$];
    int   fd_q[$];
    logic [7:0] img [H][W];

    dog_extrema_detect #(.IMG_W(W), .IMG_H(H), .THRESH(TH), .CW(CW)) dut (
        .clk(clk),
        .irst(irst),
        .idata(idata),
        .okey(okey),
        .ox(ox),
        .oy(oy),
        .ocenter(ocenter),
        .oframe_done(oframe_done)
`ifdef DOG_KEY_COUNT_EN
        ,
        .okey_count(okey_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_key(input int cx, input int cy);
        int c;
        c = img[cy][cx];
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dx == 0 && dy == 0) && img[cy+dy][cx+dx] >= c) return 1'b0;
        return c > TH;
    endfunction

    task automatic clear_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'd0;
    endtask

    // Drives n_pix pixels (wrapping across frames), optionally idle every other cycle,
    // pushes model expectations at drive time and checks outputs after every edge.
    task automatic run_frame(input bit gap, input int n_pix, input bit drain);
        int   p, tail, q, px, py, fd;
        bit   ph;
        key_t e;
        p = 0; tail = 0; ph = 1'b0;
        keys_seen = 0; frames_seen = 0;
        while (p < n_pix || tail < (drain ? 4 : 0)) begin
            if (p < n_pix && !(gap && ph)) begin
                q  = p % (W * H);
                px = q % W;
                py = q / W;
                idata = {1'b1, img[py][px]};
                if (px >= 2 && py >= 2 && model_key(px - 1, py - 1)) begin
                    e.due = cyc + 3; e.x = px - 1; e.y = py - 1; e.c = img[py-1][px-1];
                    key_q.push_back(e);
                end
                if (q == W * H - 1) fd_q.push_back(cyc + 3);
                p++;
            end else begin
                idata = {1'b0, 8'($urandom)};
                if (p >= n_pix) tail++;
            end
            ph = ~ph;
            @(negedge clk);
            if (okey === 1'b1) begin
                keys_seen++;
                last_x = int'(ox); last_y = int'(oy); last_c = int'(ocenter);
                checks++;
                if (key_q.size() == 0) begin
                    failures++;
                    $display("FAIL okey_unexpected cyc=%0d got=(%0d,%0d,%0d) want=none", cyc, ox, oy, ocenter);
                end else begin
                    e = key_q.pop_front();
                    if (e.due != cyc || {ox, oy, ocenter} !== {CW'(e.x), CW'(e.y), 8'(e.c)}) begin
                        failures++;
                        $display("FAIL okey_match got cyc=%0d (%0d,%0d,%0d) want cyc=%0d (%0d,%0d,%0d)",
                                 cyc, ox, oy, ocenter, e.due, e.x, e.y, e.c);
                    end
                end
            end else if (key_q.size() > 0 && key_q[0].due <= cyc) begin
                checks++; failures++;
                e = key_q.pop_front();
                $display("FAIL okey_missed cyc=%0d got=okey %b want=(%0d,%0d,%0d) at %0d", cyc, okey, e.x, e.y, e.c, e.due);
            end
            if (oframe_done === 1'b1) begin
                frames_seen++;
                checks++;
                if (fd_q.size() == 0) begin
                    failures++;
                    $display("FAIL frame_done_unexpected cyc=%0d got=1 want=0", cyc);
                end else begin
                    fd = fd_q.pop_front();
                    if (fd != cyc) begin
                        failures++;
                        $display("FAIL frame_done_time got cyc=%0d want cyc=%0d", cyc, fd);
                    end
                end
            end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
                checks++; failures++;
                fd = fd_q.pop_front();
                $display("FAIL frame_done_missed cyc=%0d got=%b want=1 at %0d", cyc, oframe_done, fd);
            end
        end
        idata = 9'h000;
    endtask

    task automatic test_reset();
        irst  = 1'b1;
        idata = 9'h1FF;
        repeat (3) @(negedge clk);
        checks++;
        if ({okey, ox, oy, ocenter, oframe_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got okey=%b ox=%0d oy=%0d c=%0d fd=%b want all 0", okey, ox, oy, ocenter, oframe_done);
        end
        irst  = 1'b0;
        idata = 9'h000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (okey !== 1'b0 || oframe_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got okey=%b fd=%b want 0 0", i, okey, oframe_done);
            end
        end
    endtask

    task automatic test_zero_frame();
        clear_img();
        run_frame(1'b0, W * H, 1'b1);
        checks++;
        if (keys_seen != 0 || frames_seen != 1) begin
            failures++;
            $display("FAIL zero_frame got keys=%0d frames=%0d want 0 1", keys_seen, frames_seen);
        end
    endtask

    task automatic check_single_peak(input string name);
        checks++;
        if (keys_seen != 1 || frames_seen != 1 || last_x != 3 || last_y != 3 || last_c != 50) begin
            failures++;
            $display("FAIL %s got keys=%0d frames=%0d at (%0d,%0d,%0d) want 1 1 at (3,3,50)",
                     name, keys_seen, frames_seen, last_x, last_y, last_c);
        end
`ifdef DOG_KEY_COUNT_EN
        checks++;
        if (okey_count !== 16'd1) begin
            failures++;
            $display("FAIL %s_count got=%0d want=1", name, okey_count);
        end
`endif
    endtask

    task automatic test_single_peak();
        clear_img();
        img[3][3] = 8'd50;
        run_frame(1'b0, W * H, 1'b1);
        check_single_peak("single_peak");
    endtask

    task automatic test_no_key();
        clear_img();
        img[3][3] = 8'd50; img[3][4] = 8'd50;
        img[5][5] = 8'd8;
        img[4][0] = 8'd90; img[7][7] = 8'd90;
        run_frame(1'b0, W * H, 1'b1);
        checks++;
        if (keys_seen != 0 || frames_seen != 1) begin
            failures++;
            $display("FAIL no_key got keys=%0d frames=%0d want 0 1", keys_seen, frames_seen);
        end
    endtask

    task automatic test_gaps();
        clear_img();
        img[3][3] = 8'd50;
        run_frame(1'b1, W * H, 1'b1);
        check_single_peak("gap_peak");
    endtask

    task automatic test_mid_reset();
        clear_img();
        img[3][3] = 8'd50;
        run_frame(1'b0, 4 * W + 4, 1'b0);
        irst = 1'b1;
        #1;
        checks++;
        if ({okey, ox, oy, ocenter, oframe_done} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got okey=%b ox=%0d oy=%0d c=%0d fd=%b want all 0", okey, ox, oy, ocenter, oframe_done);
        end
        key_q.delete();
        fd_q.delete();
        repeat (2) @(negedge clk);
        irst = 1'b0;
        run_frame(1'b0, W * H, 1'b1);
        check_single_peak("after_reset");
    endtask

    task automatic test_back_to_back();
        clear_img();
        img[3][3] = 8'd50;
        img[6][6] = 8'd200;
        run_frame(1'b0, 2 * W * H, 1'b1);
        checks++;
        if (keys_seen != 4 || frames_seen != 2) begin
            failures++;
            $display("FAIL back_to_back got keys=%0d frames=%0d want 4 2", keys_seen, frames_seen);
        end
`ifdef DOG_KEY_COUNT_EN
        checks++;
        if (okey_count !== 16'd2) begin
            failures++;
            $display("FAIL back_to_back_count got=%0d want=2", okey_count);
        end
`endif
    endtask

    initial begin
        irst  = 1'b1;
        idata = 9'h000;
        @(negedge clk);
        test_reset();
        test_zero_frame();
        test_single_peak();
        test_no_key();
        test_gaps();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
